// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with one outstanding imem request and redirect flush
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   stall                         decode cannot accept; holds the output slot
//   redirect, NPC                 PC override and its target (NPC[1:0] ignored)
//   imem_req, imem_addr           fetch request and address (fetch_pc)
//   imem_ready                    request accepted when imem_req & imem_ready
//   imem_valid, imem_rdata        single-cycle response pulse and word
//   IR, PC, PC_plus_4, ir_valid   output slot to decode; consumed on ir_valid & !stall
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] NPC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IR,
    output logic [31:0] PC,
    output logic [31:0] PC_plus_4,
    output logic        ir_valid
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_t;
    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_pc;
    logic        w_accept;
    logic [31:0] w_target;
    // Only request when the slot is empty or is being consumed this cycle.
    assign imem_req  = (r_state == S_REQ) & (!ir_valid | !stall);
    assign imem_addr = r_fetch_pc;
    assign w_accept  = imem_req & imem_ready;
    assign w_target  = NPC & 32'hFFFF_FFFC;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_REQ;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
            ir_valid   <= 1'b0;
            IR         <= 32'h0;
            PC         <= RESET_PC;
            PC_plus_4  <= RESET_PC + 32'd4;
        end else if (redirect) begin
            // Redirect flushes the slot and any in-flight word; an accepted or
            // still-pending request must have its response drained first.
            r_fetch_pc <= w_target;
            ir_valid   <= 1'b0;
            r_state    <= (r_state == S_REQ)  ? (w_accept ? S_DRAIN : S_REQ) :
                          (r_state == S_WAIT) ? (imem_valid ? S_REQ : S_DRAIN) : S_DRAIN;
        end else begin
            if (ir_valid && !stall)
                ir_valid <= 1'b0;
            case (r_state)
                S_REQ: begin
                    if (w_accept) begin
                        r_req_pc   <= r_fetch_pc;
                        r_fetch_pc <= r_fetch_pc + 32'd4;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_valid) begin
                        IR        <= imem_rdata;
                        PC        <= r_req_pc;
                        PC_plus_4 <= r_req_pc + 32'd4;
                        ir_valid  <= 1'b1;
                        r_state   <= S_REQ;
                    end
                end
                default: begin
                    if (imem_valid)
                        r_state <= S_REQ;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench with imem responder and delivery scoreboard for fetch_unit
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [31:0] NPC;
    logic        imem_req, imem_ready, imem_valid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] IR, PC, PC_plus_4;
    logic        ir_valid;
    int          checks = 0;
    int          errors = 0;
    int          lat = 0;
    logic        m_pend;
    int          m_cnt;
    logic [31:0] m_addr;
    logic [31:0] dq[$];
    logic [31:0] mf;
    always #5 clk = ~clk;
    fetch_unit #(.RESET_PC(RST_PC)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .NPC(NPC),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .IR(IR), .PC(PC), .PC_plus_4(PC_plus_4), .ir_valid(ir_valid)
    );
    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_iv();
        int n = 0;
        while (ir_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("wait_ir_valid", {31'h0, ir_valid}, 32'h1);
    endtask
    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("wait_imem_req", {31'h0, imem_req}, 32'h1);
    endtask
    // Memory responder: word arrives lat cycles after the accept edge's next cycle.
    always @(posedge clk) begin
        if (rst) begin
            imem_valid <= 1'b0;
            m_pend     <= 1'b0;
        end else begin
            imem_valid <= 1'b0;
            if (m_pend) begin
                if (m_cnt == 0) begin
                    imem_valid <= 1'b1;
                    imem_rdata <= word(m_addr);
                    m_pend     <= 1'b0;
                end else
                    m_cnt <= m_cnt - 1;
            end
            if (imem_req && imem_ready) begin
                if (lat == 0) begin
                    imem_valid <= 1'b1;
                    imem_rdata <= word(imem_addr);
                end else begin
                    m_pend <= 1'b1;
                    m_cnt  <= lat - 1;
                    m_addr <= imem_addr;
                end
            end
        end
    end
    // Scoreboard: accepted addresses are pushed in program order, popped on consume.
    always @(negedge clk) begin
        if (rst) begin
            dq.delete();
            mf = RST_PC;
        end else begin
            if (ir_valid && !stall && !redirect) begin
                if (dq.size() == 0)
                    chk("deliver_unexpected", PC, 32'hFFFF_FFFF);
                else begin
                    logic [31:0] e;
                    e = dq.pop_front();
                    chk("sb_pc", PC, e);
                    chk("sb_pc4", PC_plus_4, e + 32'd4);
                    chk("sb_ir", IR, word(e));
                end
            end
            if (imem_req && imem_ready) begin
                chk("sb_addr", imem_addr, mf);
                if (!redirect)
                    dq.push_back(mf);
                mf = mf + 32'd4;
            end
            if (redirect) begin
                dq.delete();
                mf = NPC & 32'hFFFF_FFFC;
            end
        end
    end
    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; NPC = 32'h0; imem_ready = 1'b1;
        imem_rdata = 32'h0;
        repeat (2) step();
        chk("rst_ir_valid", {31'h0, ir_valid}, 32'h0);
        chk("rst_pc", PC, 32'h100);
        chk("rst_pc4", PC_plus_4, 32'h104);
        chk("rst_ir", IR, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h1);
        chk("rst_addr", imem_addr, 32'h100);
        rst = 1'b0;
        step();
        chk("wait_req_low", {31'h0, imem_req}, 32'h0);
        chk("lat_iv_t1", {31'h0, ir_valid}, 32'h0);
        step();
        chk("lat_iv_t2", {31'h0, ir_valid}, 32'h1);
        chk("first_pc", PC, 32'h100);
        chk("first_pc4", PC_plus_4, 32'h104);
        chk("first_ir", IR, word(32'h100));
        chk("second_addr", imem_addr, 32'h104);
        step();
        wait_iv();
        chk("t1_pc2", PC, 32'h104);
        stall = 1'b1;
        #1;
        chk("stall_req", {31'h0, imem_req}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_hold_pc", PC, 32'h104);
            chk("stall_hold_ir", IR, word(32'h104));
            chk("stall_hold_req", {30'h0, imem_req, ir_valid}, 32'h1);
        end
        stall = 1'b0;
        #1;
        chk("release_req", {31'h0, imem_req}, 32'h1);
        chk("release_addr", imem_addr, 32'h108);
        step();
        wait_iv();
        chk("t2_pc", PC, 32'h108);
        lat = 2;
        step();
        redirect = 1'b1; NPC = 32'h200;
        step();
        redirect = 1'b0;
        chk("redir_wait_iv", {31'h0, ir_valid}, 32'h0);
        chk("redir_wait_req", {31'h0, imem_req}, 32'h0);
        wait_req();
        chk("redir_addr", imem_addr, 32'h200);
        lat = 0;
        wait_iv();
        chk("redir_pc", PC, 32'h200);
        chk("redir_pc4", PC_plus_4, 32'h204);
        stall = 1'b1; redirect = 1'b1; NPC = 32'h300;
        step();
        redirect = 1'b0; stall = 1'b0;
        chk("redir_stall_iv", {31'h0, ir_valid}, 32'h0);
        chk("redir_stall_req", {31'h0, imem_req}, 32'h1);
        chk("redir_stall_addr", imem_addr, 32'h300);
        step();
        chk("coincide_valid", {31'h0, imem_valid}, 32'h1);
        redirect = 1'b1; NPC = 32'h400;
        step();
        redirect = 1'b0;
        chk("coincide_iv", {31'h0, ir_valid}, 32'h0);
        chk("coincide_nodrain", {31'h0, imem_req}, 32'h1);
        chk("coincide_addr", imem_addr, 32'h400);
        step();
        wait_iv();
        chk("coincide_pc", PC, 32'h400);
        redirect = 1'b1; NPC = 32'hFFFF_FFFF;
        step();
        redirect = 1'b0;
        chk("drain_iv", {31'h0, ir_valid}, 32'h0);
        chk("drain_req", {31'h0, imem_req}, 32'h0);
        step();
        chk("wrap_req", {31'h0, imem_req}, 32'h1);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        wait_iv();
        chk("wrap_pc", PC, 32'hFFFF_FFFC);
        chk("wrap_pc4", PC_plus_4, 32'h0);
        chk("wrap_next_addr", imem_addr, 32'h0);
        stall = 1'b1; redirect = 1'b1; NPC = 32'h203;
        step();
        redirect = 1'b0; stall = 1'b0;
        chk("npc_align_req", {31'h0, imem_req}, 32'h1);
        chk("npc_align_addr", imem_addr, 32'h200);
        lat = 3;
        step();
        rst = 1'b1;
        step();
        chk("midrst_iv", {31'h0, ir_valid}, 32'h0);
        chk("midrst_req", {31'h0, imem_req}, 32'h1);
        chk("midrst_addr", imem_addr, 32'h100);
        chk("midrst_pc", PC, 32'h100);
        rst = 1'b0; lat = 0;
        step();
        wait_iv();
        chk("post_rst_pc", PC, 32'h100);
        repeat (4) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
